// File: rtl/ysyx_25040111_trap_seq.sv
// Trap/return sequencer: drives the CSR file's write/read/error-capture ports for exceptions and mret.
// Define YSYX_25040111_TRAP_MSTATUS_EN to add the mstatus read-modify-write states.
module ysyx_25040111_trap_seq #(
  parameter int          CAUSE_W   = 4,
  parameter logic [11:0] A_MSTATUS = 12'h300,
  parameter logic [11:0] A_MTVEC   = 12'h305,
  parameter logic [11:0] A_MEPC    = 12'h341
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               trap_valid,
  input  logic [31:0]        trap_pc,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic               mret_valid,
  output logic               req_ready,
  output logic               busy,
  output logic               csr_wen,
  output logic [11:0]        csr_waddr,
  output logic [31:0]        csr_wdata,
  output logic               csr_ren,
  output logic [11:0]        csr_raddr,
  input  logic [31:0]        csr_rdata,
  output logic               csr_err,
  output logic [CAUSE_W-1:0] csr_errtp,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_EPC   = 3'd1,
    T_CAUSE = 3'd2,
    T_VEC   = 3'd3,
    R_EPC   = 3'd4,
    DONE    = 3'd5,
    S_RD    = 3'd6,
    S_WR    = 3'd7
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        pc_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [31:0]        target_q;
  logic               accept;

  assign accept = (state == IDLE) && (trap_valid || mret_valid);

`ifdef YSYX_25040111_TRAP_MSTATUS_EN
  logic [31:0] st_q;
  logic        mret_q;

  // Trap stacks MIE into MPIE and clears MIE; mret restores MIE and sets MPIE. MPP is forced to M.
  function automatic logic [31:0] mstatus_next(input logic [31:0] st, input logic is_mret);
    logic [31:0] r;
    r = st;
    if (is_mret) begin
      r[3] = st[7];
      r[7] = 1'b1;
    end else begin
      r[7] = st[3];
      r[3] = 1'b0;
    end
    r[12:11] = 2'b11;
    return r;
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
      st_q     <= '0;
      mret_q   <= 1'b0;
`endif
    end else begin
      if (accept && trap_valid) begin
        pc_q    <= trap_pc;
        cause_q <= trap_cause;
      end
      // Direct mode only: mtvec mode bits are dropped.
      if (state == T_VEC) target_q <= {csr_rdata[31:2], 2'b00};
      if (state == R_EPC) target_q <= csr_rdata;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
      if (accept)         mret_q <= ~trap_valid;
      if (state == S_RD)  st_q   <= csr_rdata;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trap_valid) state_nxt = T_EPC;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
        else if (mret_valid) state_nxt = S_RD;
`else
        else if (mret_valid) state_nxt = R_EPC;
`endif
      end
      T_EPC:   state_nxt = T_CAUSE;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
      T_CAUSE: state_nxt = S_RD;
      S_RD:    state_nxt = S_WR;
      S_WR:    state_nxt = mret_q ? R_EPC : T_VEC;
`else
      T_CAUSE: state_nxt = T_VEC;
`endif
      T_VEC:   state_nxt = DONE;
      R_EPC:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // err sits in its own cycle because the CSR file ignores err while wen is high.
  always_comb begin
    req_ready      = (state == IDLE);
    busy           = (state != IDLE);
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    csr_ren        = 1'b0;
    csr_raddr      = '0;
    csr_err        = 1'b0;
    csr_errtp      = '0;
    redirect_valid = 1'b0;
    case (state)
      T_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = pc_q;
      end
      T_CAUSE: begin
        csr_err   = 1'b1;
        csr_errtp = cause_q;
      end
      T_VEC: begin
        csr_ren   = 1'b1;
        csr_raddr = A_MTVEC;
      end
      R_EPC: begin
        csr_ren   = 1'b1;
        csr_raddr = A_MEPC;
      end
      DONE: redirect_valid = 1'b1;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
      S_RD: begin
        csr_ren   = 1'b1;
        csr_raddr = A_MSTATUS;
      end
      S_WR: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = mstatus_next(st_q, mret_q);
      end
`endif
      default: ;
    endcase
  end

  assign redirect_pc = target_q;

endmodule
